// File: rtl/btn_pkg.sv
// btn_pkg: shared types and default parameters for the button conditioner.
// The state enum and the defaults are used by btn_debounce_channel and btn_conditioner.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // level 0, input quiet
    ARMING    = 2'd1,  // level 0, counting a candidate press
    HELD      = 2'd2,  // level 1, input steady
    RELEASING = 2'd3   // level 1, counting a candidate release
  } btn_state_t;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_DEBOUNCE_BITS = 16;
  localparam int DEFAULT_REPEAT_BITS   = 24;

  // The debounced level is high in both states that follow an accepted press.
  function automatic logic level_of(btn_state_t st);
    return (st == HELD) || (st == RELEASING);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// btn_debounce_channel: synchronizer, debounce FSM and registered strobes for one button.
// A level change needs 2**DEBOUNCE_BITS consecutive contrary synchronized samples.
// Optional feature macro: BTN_AUTOREPEAT_EN adds a press auto-repeat every 2**REPEAT_BITS
// cycles while the button is held.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS,
  parameter int REPEAT_BITS   = DEFAULT_REPEAT_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  // Reject configurations the synchronizer and counters cannot support.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_debounce_channel: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_BITS < 1 || REPEAT_BITS < 1) begin : g_bad_width
    $error("btn_debounce_channel: counter widths must be at least 1");
  end

  // Window end: the counter is compared against D-1 and so never wraps.
  localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = '1;
  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE  = DEBOUNCE_BITS'(1);

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     s;
  btn_state_t               state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     press_q, press_d;
  logic                     release_q, release_d;
  logic                     rpt_fire;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Next-state, window counter and strobe decode for the debounce FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!s) begin
          state_d = IDLE;        // glitch: discard the partial window
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASING: begin
        if (s) begin
          state_d = HELD;        // release bounce: still held
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [REPEAT_BITS-1:0] RPT_LAST = '1;

  logic [REPEAT_BITS-1:0] rpt_q, rpt_d;

  // Repeat timer: runs while the level is high and clears when the channel returns to IDLE,
  // so it never fires in the same cycle as the release strobe.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (level_of(state_q) && (state_d != IDLE)) begin
      if (rpt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // FSM state, window counter and registered strobes.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register here; there is no memory array to exempt.
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d | rpt_fire;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_of(state_q);
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: BTN_COUNT independent debounce channels for the board push-buttons.
// Produces debounced levels and single-cycle press/release strobes per button.
// Optional feature macro: BTN_AUTOREPEAT_EN (press auto-repeat while held).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int BTN_COUNT     = 4,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = DEFAULT_DEBOUNCE_BITS,
  parameter int REPEAT_BITS   = DEFAULT_REPEAT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BTN_COUNT-1:0] btn_raw,
  output logic [BTN_COUNT-1:0] btn_level,
  output logic [BTN_COUNT-1:0] btn_press,
  output logic [BTN_COUNT-1:0] btn_release
);

  // One identical channel per button; no cross-channel interaction.
  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_ch
    btn_debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_BITS(DEBOUNCE_BITS),
      .REPEAT_BITS  (REPEAT_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule
